// File: rtl/difftest_arch_int_reg_shadow_if.sv
// Commit writeback bundle from the ROB into the architectural integer register shadow.
// Lane i occupies waddr[5i+4:5i] and wdata[64i+63:64i]; lane 0 is the oldest.
interface difftest_arch_int_reg_shadow_if #(
  parameter int COMMIT_WIDTH = 2
);
  logic [COMMIT_WIDTH-1:0]    commit_valid;
  logic [COMMIT_WIDTH-1:0]    commit_wen;
  logic [5*COMMIT_WIDTH-1:0]  commit_waddr;
  logic [64*COMMIT_WIDTH-1:0] commit_wdata;
  logic [7:0]                 coreid;

  modport master (
    output commit_valid,
    output commit_wen,
    output commit_waddr,
    output commit_wdata,
    output coreid
  );

  modport slave (
    input commit_valid,
    input commit_wen,
    input commit_waddr,
    input commit_wdata,
    input coreid
  );
endinterface

// File: rtl/difftest_arch_int_reg_shadow.sv
// Committed-state copy of x0..x31 feeding the difftest ArchIntRegState sink, with
// a registered enable pulse per commit cycle and an idle heartbeat.
module difftest_arch_int_reg_shadow #(
  parameter int COMMIT_WIDTH = 2,
  parameter int HEARTBEAT    = 1024
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  difftest_arch_int_reg_shadow_if.slave        io,
  output logic                                 out_enable,
  output logic [2047:0]                        out_value,
  output logic [7:0]                           out_coreid,
  output logic [63:0]                          out_commit_cnt
);

  logic        run;
  logic        any_valid;
  logic        hb_fire;
  logic [63:0] n_valid;
  logic [63:0] regs      [32];
  logic [63:0] regs_next [32];

  // Lanes are applied oldest to youngest so the youngest writer of a register wins;
  // run stays low for the cycle in which reset releases, so that commit is dropped.
  always_comb begin
    any_valid = run && (|io.commit_valid);
    n_valid   = '0;
    regs_next = regs;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (io.commit_valid[i]) begin
        n_valid = n_valid + 64'd1;
      end
      if (run && io.commit_valid[i] && io.commit_wen[i]) begin
        regs_next[io.commit_waddr[5*i +: 5]] = io.commit_wdata[64*i +: 64];
      end
    end
    regs_next[0] = '0;
  end

  always_comb begin
    out_value = '0;
    for (int j = 0; j < 32; j++) begin
      out_value[64*j +: 64] = regs[j];
    end
  end

  generate
    if (HEARTBEAT > 0) begin : g_heartbeat
      localparam int IW = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
      logic [IW-1:0] idle_cnt;

      assign hb_fire = run && !any_valid && (idle_cnt == IW'(HEARTBEAT - 1));

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          idle_cnt <= '0;
        end else if (run) begin
          if (any_valid || hb_fire) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
      end
    end else begin : g_no_heartbeat
      assign hb_fire = 1'b0;
    end
  endgenerate

  // Register file, enable and commit counter update in the same stage so the sink
  // always samples a post-commit snapshot together with its enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run            <= 1'b0;
      out_enable     <= 1'b0;
      out_coreid     <= '0;
      out_commit_cnt <= '0;
      for (int j = 0; j < 32; j++) begin
        regs[j] <= '0;
      end
    end else begin
      run        <= 1'b1;
      out_enable <= any_valid || hb_fire;
      out_coreid <= io.coreid;
      if (run) begin
        out_commit_cnt <= out_commit_cnt + n_valid;
      end
      regs <= regs_next;
    end
  end

endmodule

// File: doc/difftest_arch_int_reg_shadow.md
Name: difftest_arch_int_reg_shadow

Overview:
- Architectural integer register shadow that sits directly upstream of the difftest ArchIntRegState sink.
- Consumes per-cycle commit writeback ports from the ROB.
- Maintains a 32 x 64-bit committed-state copy of x0..x31.
- Drives the flattened value bus, sink enable and core id that the sink samples every clock edge.

Parameters:
- COMMIT_WIDTH, 2, number of commit writeback lanes per cycle (1..4); lane 0 is oldest in program order.
- HEARTBEAT, 1024, idle cycles with no commit before a forced enable pulse; 0 disables the heartbeat.

Ports:
- clock  input  1  sole clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- io_commit_valid  input  COMMIT_WIDTH  lane i carries a committed instruction this cycle.
- io_commit_wen  input  COMMIT_WIDTH  lane i writes an integer register; ignored unless valid[i].
- io_commit_waddr  input  5*COMMIT_WIDTH  lane i destination, bits [5i+4:5i].
- io_commit_wdata  input  64*COMMIT_WIDTH  lane i result, bits [64i+63:64i].
- io_coreid  input  8  hart id, quasi-static.
- out_enable  output  1  one-cycle pulse to the sink's enable.
- out_value  output  2048  register j at bits [64j+63:64j]; maps to the sink's io_value_j.
- out_coreid  output  8  registered copy of io_coreid.
- out_commit_cnt  output  64  total committed instructions since reset.

Behaviour:
- Reset (async assert, sync release):
  - All 32 shadow registers = 0; out_enable = 0; out_coreid = 0; out_commit_cnt = 0; idle counter = 0.
- Write rule per cycle:
  - Lane i updates reg[waddr_i] <= wdata_i when valid[i] && wen[i] && waddr_i != 0.
  - x0 is never written; out_value[63:0] is constantly 0.
- Same-register conflict:
  - Several lanes targeting the same register in one cycle: the highest-index (youngest) lane wins.
  - Lanes that are valid but have wen=0 never mask an older lane's write.
- Latency:
  - Commit in cycle T is visible on out_value after the posedge ending T, i.e. during T+1.
  - out_enable is asserted in T+1 in the same registered stage, so the sink samples a consistent post-commit state.
- out_enable:
  - Registered.
  - 1 in cycle T+1 iff any valid[i] was set in cycle T, or the heartbeat fired in T.
  - Never held high 2+ cycles unless commits occur on consecutive cycles.
- out_commit_cnt:
  - Adds popcount(io_commit_valid) each cycle, counting valid lanes regardless of wen.
  - Wraps modulo 2^64.
- Heartbeat:
  - Idle counter increments each cycle with no valid lane; clears on any valid lane.
  - When the counter reaches HEARTBEAT-1 with no valid lane that cycle, it fires: out_enable pulses next cycle and the counter clears.
  - Disabled entirely when HEARTBEAT = 0.
- out_coreid: registered every cycle from io_coreid.
- Reset asserted mid-operation:
  - Immediate clear of all state.
  - Any commit present in the cycle reset deasserts is dropped.
  - The first accepted commit is the one in the first full cycle after release.
- Invalid lanes:
  - waddr/wdata are don't-care.
  - X on an invalid lane must not propagate into state.
- Lane ordering: no assumption that valid lanes are contiguous; any mask pattern is legal.

Test Plan:
- Reset, then idle 5 cycles → out_value all 0, out_enable 0, out_commit_cnt 0, out_coreid = io_coreid after 1 cycle.
- Lane0 valid/wen, waddr 5, wdata 0xDEAD_BEEF_0000_0001 at cycle T → during T+1 bits [383:320] = 0xDEADBEEF00000001, out_enable=1 only in T+1, out_commit_cnt = 1.
- Both lanes write x7 (lane0 0x11, lane1 0x22) → x7 = 0x22; then lane0 x7=0x33 wen=1 with lane1 valid wen=0 → x7 = 0x33; out_commit_cnt +2 each cycle.
- Write waddr 0, wdata 0xFFFF... → out_value[63:0] stays 0, out_enable still pulses, out_commit_cnt increments.
- HEARTBEAT=8, no commits after reset → out_enable pulses on cycles 9, 17, 25 after release; a commit at cycle 12 moves the next heartbeat pulse to cycle 21.
- Assert reset_n low mid-stream after x3=0x55 → out_value, out_commit_cnt, out_enable clear asynchronously without waiting for a clock edge.
